// File: rtl/ctrl_useq.sv
// ctrl_useq: microcoded control sequencer. Each accepted opcode expands into
// 1..2^STEP_W control words read from a writable store, issued via valid/ready.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module   : ctrl_useq                                                     |
// | Purpose  : opcode -> microcode word sequencer with valid/ready output    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ctrl_useq #(
   parameter int OPC_W  = 7,
   parameter int CTRL_W = 26,
   parameter int STEP_W = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPC_W-1:0]        in_opc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CTRL_W-1:0]       out_ctrl,
   output logic [OPC_W-1:0]        out_opc,
   output logic [STEP_W-1:0]       out_step,
   output logic                    out_last,
   input  logic                    flush,
   input  logic                    cfg_we,
   input  logic [OPC_W+STEP_W-1:0] cfg_addr,
   input  logic [CTRL_W:0]         cfg_data
);

   localparam int                ADDR_W   = OPC_W + STEP_W;
   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [STEP_W-1:0] STEP_MAX = '1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t              r_state;
   logic                r_valid;
   logic [CTRL_W-1:0]   r_ctrl;
   logic [OPC_W-1:0]    r_opc;
   logic [STEP_W-1:0]   r_step;
   logic                r_last;

   // Microcode store is deliberately not reset so contents survive rst_n.
   logic [CTRL_W:0]     r_mem [0:DEPTH-1];

   logic                w_accept;
   logic [OPC_W-1:0]    w_ld_opc;
   logic [STEP_W-1:0]   w_ld_step;
   logic [CTRL_W:0]     w_ld_word;
   logic                w_ld_last;

   always_ff @(posedge clk) begin
      if (cfg_we) begin
         r_mem[cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      in_ready = rst_n & ~flush &
                 ((r_state == ST_IDLE) | (r_valid & out_ready & r_last));
   end

   assign w_accept  = in_valid & in_ready;
   assign w_ld_opc  = w_accept ? in_opc : r_opc;
   assign w_ld_step = w_accept ? '0 : r_step + STEP_W'(1);
   // Combinational read: a same-edge write lands after this value is captured.
   assign w_ld_word = r_mem[{w_ld_opc, w_ld_step}];
   assign w_ld_last = w_ld_word[CTRL_W] | (w_ld_step == STEP_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_opc   <= '0;
         r_step  <= '0;
         r_last  <= 1'b0;
      end else if (flush) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_ISSUE;
                  r_valid <= 1'b1;
                  r_ctrl  <= w_ld_word[CTRL_W-1:0];
                  r_opc   <= w_ld_opc;
                  r_step  <= w_ld_step;
                  r_last  <= w_ld_last;
               end
            end
            ST_ISSUE: begin
               if (out_ready) begin
                  if (!r_last || w_accept) begin
                     r_ctrl <= w_ld_word[CTRL_W-1:0];
                     r_opc  <= w_ld_opc;
                     r_step <= w_ld_step;
                     r_last <= w_ld_last;
                  end else begin
                     r_state <= ST_IDLE;
                     r_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign out_ctrl  = r_ctrl;
   assign out_opc   = r_opc;
   assign out_step  = r_step;
   assign out_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_useq.sv
// tb_ctrl_useq: directed + random stimulus, scoreboard of expected words
// derived from a shadow microcode array and opcode-expansion rules.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module   : tb_ctrl_useq                                                  |
// | Purpose  : self-checking bench for ctrl_useq                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ctrl_useq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [25:0] out_ctrl;
   logic [6:0]  out_opc;
   logic [1:0]  out_step;
   logic        out_last;
   logic        flush = 1'b0;
   logic        cfg_we = 1'b0;
   logic [8:0]  cfg_addr = '0;
   logic [26:0] cfg_data = '0;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [25:0] ctrl;
      logic [6:0]  opc;
      logic [1:0]  step;
      logic        last;
   } exp_t;

   exp_t        q[$];
   logic [26:0] ref_mem [512];
   logic        rst_at_edge = 1'b0;

   ctrl_useq #(.OPC_W(7), .CTRL_W(26), .STEP_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
      .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_opc(out_opc), .out_step(out_step), .out_last(out_last),
      .flush(flush), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expand one opcode from step 1 on, using the store as it stands after this edge.
   task automatic expand_rest(input logic [6:0] opc);
      for (int s = 1; s < 4; s++) begin
         logic [1:0]  st;
         logic [26:0] w;
         exp_t        e;
         st = 2'(s);
         w  = ref_mem[{opc, st}];
         e.ctrl = w[25:0];
         e.opc  = opc;
         e.step = st;
         e.last = w[26] | (s == 3);
         q.push_back(e);
         if (e.last) break;
      end
   endtask

   always @(posedge clk) rst_at_edge = rst_n;

   always @(negedge clk) begin
      logic exp_ir;
      logic acc;
      exp_t e0;
      acc = 1'b0;
      e0  = '0;
      if (!rst_n) begin
         chk("in_ready_rst", {63'd0, in_ready}, 64'd0);
         if (!rst_at_edge) begin
            chk("reset_outs", {out_valid, out_ctrl, out_opc, out_step, out_last}, 64'd0);
         end
         q.delete();
      end else begin
         exp_ir = !flush && (q.size() == 0 || (out_ready && q[0].last));
         chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
         chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
         if (q.size() != 0 && out_valid)
            chk("word", {28'd0, out_ctrl, out_opc, out_step, out_last}, {28'd0, q[0]});
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && exp_ir) begin
               acc = 1'b1;
               e0.ctrl = ref_mem[{in_opc, 2'd0}][25:0];
               e0.opc  = in_opc;
               e0.step = 2'd0;
               e0.last = ref_mem[{in_opc, 2'd0}][26];
               q.push_back(e0);
            end
         end
      end
      if (cfg_we) ref_mem[cfg_addr] = cfg_data;
      if (acc && !e0.last) expand_rest(e0.opc);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input logic [6:0] opc, input logic [1:0] st, input logic last,
                         input logic [25:0] ctrl);
      cfg_we   = 1'b1;
      cfg_addr = {opc, st};
      cfg_data = {last, ctrl};
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic offer(input logic [6:0] opc);
      logic ok;
      ok = 1'b0;
      in_opc   = opc;
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted opc=%0h", opc);
      end
   endtask

   task automatic drain();
      logic ok;
      ok = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain_timeout actual=busy required=idle");
      end
   endtask

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      step();

      cfg_wr(7'h05, 2'd0, 1'b1, 26'h0000ABC);
      for (int s = 0; s < 4; s++) cfg_wr(7'h12, 2'(s), 1'b0, 26'(s + 1));
      cfg_wr(7'h21, 2'd0, 1'b0, 26'h111);
      cfg_wr(7'h21, 2'd1, 1'b1, 26'h222);
      cfg_wr(7'h22, 2'd0, 1'b1, 26'h333);
      for (int s = 0; s < 4; s++) cfg_wr(7'h30, 2'(s), 1'b0, 26'h40 + 26'(s));
      cfg_wr(7'h20, 2'd0, 1'b0, 26'hAA);
      cfg_wr(7'h20, 2'd1, 1'b1, 26'hBB);
      for (int o = 0; o < 8; o++)
         for (int s = 0; s < 4; s++)
            cfg_wr(7'(o), 2'(s), ($urandom % 3) == 0, 26'($urandom));

      // single-step, then forced-last 4-step sequence
      out_ready = 1'b1;
      offer(7'h05);
      drain();
      offer(7'h12);
      drain();

      // back-to-back opcodes with no bubble
      offer(7'h21);
      offer(7'h22);
      drain();

      // backpressure mid-sequence
      offer(7'h12);
      step();
      out_ready = 1'b0;
      repeat (3) step();
      out_ready = 1'b1;
      drain();

      // flush on step 1 with a competing opcode offered
      offer(7'h30);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_opc   = 7'h05;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      repeat (2) step();

      // reset mid-sequence; microcode must survive
      offer(7'h30);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      offer(7'h12);
      drain();

      // write collision on the edge that loads step 1
      offer(7'h20);
      cfg_we   = 1'b1;
      cfg_addr = {7'h20, 2'd1};
      cfg_data = {1'b1, 26'hCC};
      step();
      cfg_we   = 1'b0;
      drain();
      offer(7'h20);
      drain();

      // randomized traffic; random writes stay outside the offered opcodes
      for (int c = 0; c < 600; c++) begin
         out_ready = ($urandom % 4) != 0;
         in_valid  = ($urandom % 3) != 0;
         in_opc    = 7'($urandom % 8);
         flush     = ($urandom % 30) == 0;
         cfg_we    = ($urandom % 5) == 0;
         cfg_addr  = {1'b1, 6'($urandom), 2'($urandom)};
         cfg_data  = 27'($urandom);
         step();
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      cfg_we   = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
